simon_sequencer: RTL and testbench
==================================

// Module: simon_sequencer
//
// PURPOSE
//   Parametrised Simon game engine for the Pacman board. Grows a random sequence one step per round.
//   Each round it plays the full sequence back on the button LEDs, then checks the player's
//   presses in order. Sits between the debounced button decoder (player_*) and the LED/sound
//   driver (simon_*), clocked from the 60 Hz game tick.
//
// PARAMETERS
//   NUM_BUTTONS   4        number of buttons/colours, 2..16
//   MAX_LEN       16       sequence length that wins the game, 1..255
//   ON_TICKS      30       clk cycles a playback step is lit
//   OFF_TICKS     30       clk cycles dark before each playback step
//   LFSR_SEED     16'hACE1 LFSR reset value, must be nonzero
//   TIMEOUT_TICKS 300      idle cycles allowed per player press (SIMON_TIMEOUT_EN only)
//   Derived: BTN_W = max(1,$clog2(NUM_BUTTONS)); LEN_W = $clog2(MAX_LEN+1)
//
// PORTS
//   clk            in   1      game tick clock
//   reset_n        in   1      asynchronous, active-low reset
//   start          in   1      start new game; honoured only in IDLE, LOSE, WIN
//   player_num     in   BTN_W  button index currently held
//   player_pressed in   1      high while a button is held
//   simon_turn     out  1      1 while the engine owns the buttons (GEN/PLAY_*)
//   simon_num      out  BTN_W  index being shown; valid while simon_pressed=1
//   simon_pressed  out  1      playback LED on
//   level          out  LEN_W  current sequence length
//   game_over      out  1      held 1 in LOSE
//   game_won       out  1      held 1 in WIN
//
// BEHAVIOUR
//   Reset: state IDLE, LFSR=LFSR_SEED, all outputs 0, len=idx=0. Reset is effective mid-round.
//   LFSR: 16-bit Galois, poly x^16+x^14+x^13+x^11+1. Advances every cycle in every state,
//     so the sequence depends on player timing.
//   Step value: r = lfsr[BTN_W-1:0]; value = (r>=NUM_BUTTONS) ? r-NUM_BUTTONS : r.
//   FSM:
//     IDLE/LOSE/WIN --start--> GEN. Clears len, game_over and game_won.
//     GEN (1 cycle): mem[len]<=value; len<=len+1; idx<=0 -> PLAY_OFF
//     PLAY_OFF (exactly OFF_TICKS cycles, simon_pressed=0) -> PLAY_ON
//     PLAY_ON (exactly ON_TICKS cycles, simon_pressed=1, simon_num=mem[idx]):
//       if idx==len-1 -> WAIT_PRESS with idx=0; else idx++ -> PLAY_OFF
//     WAIT_PRESS: on a player_pressed rising edge (vs the registered previous value),
//       capture player_num from that same cycle -> WAIT_REL
//     WAIT_REL: on player_pressed low -> CHECK
//     CHECK (1 cycle):
//       captured != mem[idx] -> LOSE
//       else if idx==len-1: len==MAX_LEN -> WIN, otherwise -> GEN
//       else idx++ -> WAIT_PRESS
//   simon_turn=1 exactly in GEN, PLAY_OFF and PLAY_ON.
//   Player inputs are ignored while simon_turn=1.
//   A button still held on entry to WAIT_PRESS is not a press; a new rising edge is required.
//   start outside IDLE/LOSE/WIN is ignored.
//   player_num changes during WAIT_REL are ignored.
//   level = len and never exceeds MAX_LEN. The WIN check precedes any GEN, so mem never overflows.
//
// CONFIGURATION
//   SIMON_TIMEOUT_EN defined:
//     - a counter clears on each entry to WAIT_PRESS;
//     - if TIMEOUT_TICKS cycles elapse with no rising edge -> LOSE;
//     - a press on the expiring cycle wins over the timeout.
//   Not defined: WAIT_PRESS waits forever; no counter is synthesised.
//
// STRUCTURE
//   simon_pkg: state_t enum (IDLE, GEN, PLAY_OFF, PLAY_ON, WAIT_PRESS, WAIT_REL, CHECK, LOSE,
//     WIN), LFSR_TAPS = 16'hB400, DEFAULT_SEED.
//   Sub-module simon_lfsr: free-running LFSR, seed parameter.
//   Sequence memory: MAX_LEN x BTN_W register array inside simon_sequencer.
//
// TESTING (bench params: NUM_BUTTONS=4, MAX_LEN=3, ON_TICKS=2, OFF_TICKS=2, TIMEOUT_TICKS=10)
//   1. reset_n low -> all outputs 0, IDLE. Pulse start -> simon_turn=1 next cycle,
//      simon_pressed high 1+2 cycles after GEN for 2 cycles, level=1.
//   2. Perfect play of 3 rounds, each press/release matching the shown simon_num -> game_won=1,
//      level=3, game_over=0.
//   3. Round 2, wrong index on the 1st press -> game_over=1 one cycle after release;
//      start -> level=1, game_over=0.
//   4. Button held across the PLAY_ON->WAIT_PRESS transition, then released -> no check occurs;
//      the next clean press is checked.
//   5. reset_n asserted during PLAY_ON -> simon_pressed=0 immediately, level=0, LFSR=seed.
//   6. SIMON_TIMEOUT_EN: no press for 10 cycles in WAIT_PRESS -> game_over=1.
//      Without the macro: no game_over after 100 cycles.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon game engine.
// SIMON_TIMEOUT_EN (see simon_sequencer) adds a per-press idle timeout.
package simon_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GEN,
    PLAY_OFF,
    PLAY_ON,
    WAIT_PRESS,
    WAIT_REL,
    CHECK,
    LOSE,
    WIN
  } state_t;

  // Galois form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Galois LFSR; exposes only the low OUT_W bits.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED  = DEFAULT_SEED,
  parameter int unsigned OUT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [OUT_W-1:0] o_bits
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr <= SEED;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_bits = r_lfsr[OUT_W-1:0];

endmodule

// File: rtl/simon_sequencer.sv
// Simon game engine: grows a random sequence, plays it back, checks the player's presses.
// Define SIMON_TIMEOUT_EN to lose the game after TIMEOUT_TICKS idle cycles in WAIT_PRESS.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS   = 4,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned ON_TICKS      = 30,
  parameter int unsigned OFF_TICKS     = 30,
  parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED,
  parameter int unsigned TIMEOUT_TICKS = 300,
  localparam int unsigned BTN_W = ($clog2(NUM_BUTTONS) > 1) ? $clog2(NUM_BUTTONS) : 1,
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BTN_W-1:0] player_num,
  input  logic             player_pressed,
  output logic             simon_turn,
  output logic [BTN_W-1:0] simon_num,
  output logic             simon_pressed,
  output logic [LEN_W-1:0] level,
  output logic             game_over,
  output logic             game_won
);

  localparam int unsigned IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TMAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned TMAX   = (TIMEOUT_TICKS > TMAX_A) ? TIMEOUT_TICKS : TMAX_A;
  localparam int unsigned CNT_W  = $clog2(TMAX + 1);

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [BTN_W-1:0] r_cap;
  logic             r_prev;
  logic [BTN_W-1:0] r_mem [MAX_LEN];

  logic [BTN_W-1:0] w_rand;
  logic [BTN_W:0]   w_rand_ext;
  logic [BTN_W-1:0] w_val;
  logic             w_edge;
  logic             w_last;

  simon_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (BTN_W)
  ) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .o_bits  (w_rand)
  );

  // Fold out-of-range LFSR values back into 0..NUM_BUTTONS-1
  assign w_rand_ext = {1'b0, w_rand};
  assign w_val = (w_rand_ext >= (BTN_W + 1)'(NUM_BUTTONS)) ?
                 BTN_W'(w_rand_ext - (BTN_W + 1)'(NUM_BUTTONS)) : w_rand;

  assign w_edge = player_pressed & ~r_prev;
  assign w_last = (LEN_W'(r_idx) == (r_len - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (r_state == GEN) begin
      r_mem[IDX_W'(r_len)] <= w_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_prev  <= 1'b0;
    end else begin
      r_prev <= player_pressed;
      unique case (r_state)
        IDLE, LOSE, WIN: begin
          if (start) begin
            r_len   <= '0;
            r_state <= GEN;
          end
        end
        GEN: begin
          r_len   <= r_len + LEN_W'(1);
          r_idx   <= '0;
          r_cnt   <= '0;
          r_state <= PLAY_OFF;
        end
        PLAY_OFF: begin
          if (r_cnt == CNT_W'(OFF_TICKS - 1)) begin
            r_cnt   <= '0;
            r_state <= PLAY_ON;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        PLAY_ON: begin
          if (r_cnt == CNT_W'(ON_TICKS - 1)) begin
            r_cnt <= '0;
            if (w_last) begin
              r_idx   <= '0;
              r_state <= WAIT_PRESS;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= PLAY_OFF;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        WAIT_PRESS: begin
          if (w_edge) begin
            r_cap   <= player_num;
            r_state <= WAIT_REL;
          end
`ifdef SIMON_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
            r_state <= LOSE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
`endif
        end
        WAIT_REL: begin
          if (!player_pressed) begin
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (r_cap != r_mem[r_idx]) begin
            r_state <= LOSE;
          end else if (w_last) begin
            r_state <= (r_len == LEN_W'(MAX_LEN)) ? WIN : GEN;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_cnt   <= '0;
            r_state <= WAIT_PRESS;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign simon_turn    = (r_state == GEN) || (r_state == PLAY_OFF) || (r_state == PLAY_ON);
  assign simon_pressed = (r_state == PLAY_ON);
  assign simon_num     = simon_pressed ? r_mem[r_idx] : '0;
  assign level         = r_len;
  assign game_over     = (r_state == LOSE);
  assign game_won      = (r_state == WIN);

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer; honours SIMON_TIMEOUT_EN for the timeout scenario.
module tb_simon_sequencer;

  localparam int unsigned NB = 4;
  localparam int unsigned ML = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] player_num = 2'd0;
  logic       player_pressed = 1'b0;
  logic       simon_turn;
  logic [1:0] simon_num;
  logic       simon_pressed;
  logic [1:0] level;
  logic       game_over;
  logic       game_won;

  int errors = 0;
  int checks = 0;

  simon_sequencer #(
    .NUM_BUTTONS   (NB),
    .MAX_LEN       (ML),
    .ON_TICKS      (2),
    .OFF_TICKS     (2),
    .LFSR_SEED     (16'hACE1),
    .TIMEOUT_TICKS (10)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .player_num     (player_num),
    .player_pressed (player_pressed),
    .simon_turn     (simon_turn),
    .simon_num      (simon_num),
    .simon_pressed  (simon_pressed),
    .level          (level),
    .game_over      (game_over),
    .game_won       (game_won)
  );

  always #5 clk = ~clk;

  // Reference LFSR: shift right, xor taps when a one falls out
  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [1:0] step_val(input logic [15:0] s);
    logic [2:0] r;
    r = {1'b0, s[1:0]};
    if (r >= 3'(NB)) r = r - 3'(NB);
    return r[1:0];
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 16'hACE1;
    else          m_lfsr <= model_step(m_lfsr);
  end

  logic [1:0] seq[$];
  logic [1:0] exp_q[$];
  logic [1:0] mon_exp;
  logic       prev_turn = 1'b0;
  logic       prev_pressed = 1'b0;

  // Scoreboard: each GEN appends a model step and queues the full playback
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q = {};
      prev_turn    <= 1'b0;
      prev_pressed <= 1'b0;
    end else begin
      if (simon_turn && !prev_turn) begin
        seq.push_back(step_val(m_lfsr));
        exp_q = {};
        foreach (seq[i]) exp_q.push_back(seq[i]);
      end
      if (simon_pressed && !prev_pressed) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL playback_extra: simon_num=%0d shown, nothing expected", simon_num);
        end else begin
          mon_exp = exp_q.pop_front();
          if (simon_num !== mon_exp) begin
            errors++;
            $display("FAIL playback_num: simon_num=%0d expected %0d", simon_num, mon_exp);
          end
        end
      end
      prev_turn    <= simon_turn;
      prev_pressed <= simon_pressed;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    seq = {};
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_turn_end();
    int  n;
    logic seen;
    n = 0;
    seen = simon_turn;
    while (!(seen && !simon_turn) && n < 300) begin
      tick();
      n++;
      if (simon_turn) seen = 1'b1;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL turn_end_timeout: simon_turn=%0d after %0d cycles", simon_turn, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL playback_missing: %0d steps not shown, expected 0", exp_q.size());
    end
  endtask

  task automatic wait_pressed();
    int n;
    n = 0;
    while (!simon_pressed && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (!simon_pressed) begin
      errors++;
      $display("FAIL wait_pressed_timeout: simon_pressed=%0d expected 1", simon_pressed);
    end
  endtask

  task automatic press(input logic [1:0] num);
    player_num = num;
    player_pressed = 1'b1;
    tick();
    tick();
    player_pressed = 1'b0;
    tick();
    tick();
  endtask

  task automatic play_round();
    int n;
    n = seq.size();
    for (int i = 0; i < n; i++) press(seq[i]);
  endtask

  task automatic test_reset();
    logic exp_p[5];
    #2 reset_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({simon_turn, simon_num, simon_pressed, level, game_over, game_won} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: turn=%0d num=%0d pressed=%0d level=%0d over=%0d won=%0d, all 0",
               simon_turn, simon_num, simon_pressed, level, game_over, game_won);
    end
    reset_n = 1'b1;
    tick();
    pulse_start();
    checks++;
    if (simon_turn !== 1'b1 || simon_pressed !== 1'b0 || level !== 2'd0) begin
      errors++;
      $display("FAIL gen_cycle: turn=%0d pressed=%0d level=%0d expected 1 0 0",
               simon_turn, simon_pressed, level);
    end
    exp_p = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (simon_pressed !== exp_p[k]) begin
        errors++;
        $display("FAIL play_timing[%0d]: simon_pressed=%0d expected %0d", k, simon_pressed,
                 exp_p[k]);
      end
    end
    checks++;
    if (level !== 2'd1 || simon_turn !== 1'b0) begin
      errors++;
      $display("FAIL round1_wait: level=%0d turn=%0d expected 1 0", level, simon_turn);
    end
  endtask

  task automatic test_perfect_play();
    play_round();
    wait_turn_end();
    play_round();
    wait_turn_end();
    play_round();
    checks++;
    if (game_won !== 1'b1 || level !== 2'd3 || game_over !== 1'b0 || simon_turn !== 1'b0) begin
      errors++;
      $display("FAIL win: won=%0d level=%0d over=%0d turn=%0d expected 1 3 0 0",
               game_won, level, game_over, simon_turn);
    end
  endtask

  task automatic test_wrong_press();
    pulse_start();
    checks++;
    if (game_won !== 1'b0 || level !== 2'd0) begin
      errors++;
      $display("FAIL restart_from_win: won=%0d level=%0d expected 0 0", game_won, level);
    end
    wait_turn_end();
    play_round();
    wait_turn_end();
    player_num = seq[0] + 2'd1;
    player_pressed = 1'b1;
    tick();
    tick();
    player_pressed = 1'b0;
    tick();
    checks++;
    if (game_over !== 1'b0) begin
      errors++;
      $display("FAIL lose_early: game_over=%0d expected 0 during check", game_over);
    end
    tick();
    checks++;
    if (game_over !== 1'b1 || level !== 2'd2) begin
      errors++;
      $display("FAIL lose: game_over=%0d level=%0d expected 1 2", game_over, level);
    end
    pulse_start();
    tick();
    checks++;
    if (game_over !== 1'b0 || level !== 2'd1) begin
      errors++;
      $display("FAIL restart_from_lose: game_over=%0d level=%0d expected 0 1", game_over, level);
    end
  endtask

  task automatic test_held_button();
    wait_pressed();
    player_num = seq[0] + 2'd1;
    player_pressed = 1'b1;
    wait_turn_end();
    tick();
    tick();
    player_pressed = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (game_over !== 1'b0 || simon_turn !== 1'b0 || level !== 2'd1) begin
      errors++;
      $display("FAIL held_not_press: over=%0d turn=%0d level=%0d expected 0 0 1",
               game_over, simon_turn, level);
    end
    press(seq[0]);
    wait_turn_end();
    checks++;
    if (level !== 2'd2 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL after_held: level=%0d over=%0d expected 2 0", level, game_over);
    end
  endtask

  task automatic test_reset_mid_round();
    play_round();
    wait_pressed();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (simon_pressed !== 1'b0 || level !== 2'd0 || simon_turn !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: pressed=%0d level=%0d turn=%0d expected 0 0 0",
               simon_pressed, level, simon_turn);
    end
    checks++;
    if (dut.u_lfsr.r_lfsr !== 16'hACE1) begin
      errors++;
      $display("FAIL mid_reset_lfsr: lfsr=%h expected ace1", dut.u_lfsr.r_lfsr);
    end
    seq = {};
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    pulse_start();
    wait_turn_end();
`ifdef SIMON_TIMEOUT_EN
    repeat (9) tick();
    checks++;
    if (game_over !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: game_over=%0d expected 0", game_over);
    end
    tick();
    checks++;
    if (game_over !== 1'b1) begin
      errors++;
      $display("FAIL timeout: game_over=%0d expected 1", game_over);
    end
`else
    repeat (100) tick();
    checks++;
    if (game_over !== 1'b0 || simon_turn !== 1'b0 || level !== 2'd1) begin
      errors++;
      $display("FAIL no_timeout: over=%0d turn=%0d level=%0d expected 0 0 1",
               game_over, simon_turn, level);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_perfect_play();
    test_wrong_press();
    test_held_button();
    test_reset_mid_round();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
